// File: rtl/imm_pkg.sv
// Shared immediate-format encodings for the RV immediate generator.
// Every consumer of imm_src takes its codes from here.
package imm_pkg;

    localparam int          IMM_SRC_W = 3;
    localparam logic [2:0]  IMM_I     = 3'b000;
    localparam logic [2:0]  IMM_S     = 3'b001;
    localparam logic [2:0]  IMM_B     = 3'b010;
    localparam logic [2:0]  IMM_U     = 3'b011;
    localparam logic [2:0]  IMM_J     = 3'b100;
    localparam logic [2:0]  IMM_SHAMT = 3'b101;

    // Codes above SHAMT are reserved and flagged as errors.
    function automatic logic imm_src_legal(input logic [IMM_SRC_W-1:0] src);
        return src <= IMM_SHAMT;
    endfunction

endpackage

// File: rtl/imm_format.sv
// Combinational extraction of the immediate field from a raw RV instruction.
// Reserved selector codes produce imm=0 with err=1.
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr,
    input  logic [IMM_SRC_W-1:0] imm_src,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);

    // Every signed format is first built as a 32-bit value, then widened to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm = '0;
        err = !imm_src_legal(imm_src);
        case (imm_src)
            IMM_I:     imm = sext32({{20{instr[31]}}, instr[31:20]});
            IMM_S:     imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            IMM_B:     imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                     instr[11:8], 1'b0});
            IMM_U:     imm = sext32({instr[31:12], 12'h000});
            IMM_J:     imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                     instr[30:21], 1'b0});
            IMM_SHAMT: imm[5:0] = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Elastic pipeline around imm_format: STAGES valid/ready register slices,
// one result per cycle, full-throughput push/pop when the last stage drains.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [IMM_SRC_W-1:0] imm_src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      imm_ext,
    output logic                 imm_err
);

    logic [XLEN-1:0] fmt_imm;
    logic            fmt_err;

    imm_format #(.XLEN(XLEN)) u_fmt (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (fmt_imm),
        .err     (fmt_err)
    );

    // Index 0 is the incoming beat; 1..STAGES are the registered slices.
    logic [STAGES:0]           vld_pipe;
    logic [STAGES:0][XLEN-1:0] imm_pipe;
    logic [STAGES:0]           err_pipe;
    logic [STAGES:1]           rdy;

    assign vld_pipe[0] = in_valid;
    assign imm_pipe[0] = fmt_imm;
    assign err_pipe[0] = fmt_err;

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        logic            vld_r;
        logic [XLEN-1:0] imm_r;
        logic            err_r;

        // A slice can load unless it and every slice downstream is full and stalled.
        assign rdy[s] = out_ready || !(&vld_pipe[STAGES:s]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                imm_r <= '0;
                err_r <= 1'b0;
            end else if (rdy[s]) begin
                vld_r <= vld_pipe[s-1];
                if (vld_pipe[s-1]) begin
                    imm_r <= imm_pipe[s-1];
                    err_r <= err_pipe[s-1];
                end
            end
        end

        assign vld_pipe[s] = vld_r;
        assign imm_pipe[s] = imm_r;
        assign err_pipe[s] = err_r;
    end

    assign in_ready  = rdy[1];
    assign out_valid = vld_pipe[STAGES];
    assign imm_ext   = imm_pipe[STAGES];
    assign imm_err   = err_pipe[STAGES];

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter STAGES, default 1, number of register stages; legal values 1 and 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  instr/imm_src are valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts the input this cycle.
REQ-007 SHALL have port instr  input  32  raw RV instruction word.
REQ-008 SHALL have port imm_src  input  3  immediate format selector.
REQ-009 SHALL have port out_valid  output  1  imm_ext/imm_err hold a result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port imm_ext  output  XLEN  extended immediate.
REQ-012 SHALL have port imm_err  output  1  result came from an illegal imm_src.

Function
REQ-013 SHALL treat imm_src encodings as: 000 I {instr[31:20]}, 001 S {instr[31:25],instr[11:7]}, 010 B {instr[31],instr[7],instr[30:25],instr[11:8],0}, 011 U {instr[31:12],12'h000}, 100 J {instr[31],instr[19:12],instr[20],instr[30:21],0}, 101 SHAMT.
REQ-014 SHALL sign-extend I/S/B/U/J results from their top bit to XLEN; U is sign-extended from bit 31 when XLEN=64.
REQ-015 SHALL zero-extend SHAMT: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-016 SHALL output imm_ext=0 with imm_err=1 for imm_src 110 or 111; imm_err=0 for all legal codes.
REQ-017 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-018 SHALL let each stage load when it is empty or its content leaves in the same cycle; in_ready SHALL be the combinational result of this rule for stage 0.
REQ-019 SHALL deliver a result STAGES cycles after acceptance when out_ready is held high; throughput one result per cycle.
REQ-020 SHALL preserve order with no loss or duplication; capacity exactly STAGES entries.
REQ-021 SHALL hold imm_ext, imm_err, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL accept a new input in the same cycle the last stage drains when full (simultaneous push/pop).
REQ-023 SHALL ignore instr/imm_src when in_valid=0; no combinational path from in_valid to out_valid.

Reset
REQ-024 SHALL, while rst_n=0, force all stage valid flags to 0 and all stage data/err registers to 0, so that out_valid=0, imm_ext=0, imm_err=0.
REQ-025 SHALL discard in-flight results on reset mid-operation; out_valid SHALL be 0 immediately after rst_n falls, without waiting for a clk edge.
REQ-026 SHALL present in_ready=1 during and after reset.

Structure
REQ-027 SHALL take imm_src encodings (IMM_I..IMM_SHAMT) from the shared package imm_pkg as localparams; the pipeline SHALL NOT hardcode them.
REQ-028 SHALL place format extraction in a combinational sub-module imm_format (params XLEN; ports instr, imm_src, imm, err), instantiated before stage 0.
REQ-029 SHALL build stages with a generate loop of identical valid/data/err registers.

Verification
REQ-030 I/S: instr 0xFFF00093 src 000 -> imm_ext 0xFFFFFFFF; instr 0xFE112C23 src 001 -> 0xFFFFFFF8, each STAGES cycles later, err=0.
REQ-031 B/J: 0xFE000EE3 src 010 -> 0xFFFFFFFC; 0x0080006F src 100 -> 0x00000008.
REQ-032 U/SHAMT: 0x123450B7 src 011 -> 0x12345000 (XLEN=64: 0x0000000012345000); 0x41F0D093 src 101 -> 0x1F (XLEN=64 -> 0x1F).
REQ-033 Backpressure: out_ready=0 for 5 cycles, in_valid=1 with 3 distinct words -> exactly STAGES accepted, in_ready=0 after, then all delivered in order with no duplicates.
REQ-034 Illegal code: src 111, instr 0xFFFFFFFF -> imm_ext 0, imm_err 1; next legal input -> imm_err 0.
REQ-035 Reset: assert rst_n=0 with all stages full -> out_valid 0 immediately; after release, first new input is delivered with correct value.
